csr_controller: RTL and testbench

Machine-mode CSR block of the RISC-V core, directly downstream of the interrupt controller. It consumes the interrupt strobe and cause id and owns the `mie` mask fed back to that controller. It also holds the trap CSRs `mtvec`, `mscratch`, `mepc` and `mcause`, executes CSRRW/CSRRS/CSRRC, and runs the trap entry/`mret` sequence that redirects the PC and returns the interrupt-done flag.

---
 rtl/csr_pkg.sv | 51 +++++
 rtl/csr_trap_fsm.sv | 65 ++++++
 rtl/csr_controller.sv | 106 ++++++++++
 tb/tb_csr_controller.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared constants and types for the machine-mode CSR block: address map,
// CSR instruction encodings, trap FSM states and the CSR write rule.
package csr_pkg;

  // CSR address map
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;

  // CSR instruction encodings; all other codes behave as no access
  typedef enum logic [2:0] {
    CSR_OP_NONE = 3'b000,
    CSR_OP_RW   = 3'b001,
    CSR_OP_RS   = 3'b010,
    CSR_OP_RC   = 3'b011
  } csr_op_e;

  // Trap sequencing states
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } trap_state_e;

  // Interrupt flag position inside mcause
  localparam int MCAUSE_INT = 31;

  // mtvec and mepc keep their two low bits at zero (direct mode, no C extension)
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // True for the three opcodes that access a CSR
  function automatic logic csr_op_valid(input logic [2:0] op);
    return (op == CSR_OP_RW) || (op == CSR_OP_RS) || (op == CSR_OP_RC);
  endfunction

  // New CSR value for a given access type applied to the old value
  function automatic logic [31:0] csr_apply(input logic [2:0]  op,
                                            input logic [31:0] old_val,
                                            input logic [31:0] wd);
    logic [31:0] res;
    case (op)
      CSR_OP_RW: res = wd;
      CSR_OP_RS: res = old_val | wd;
      CSR_OP_RC: res = old_val & ~wd;
      default:   res = old_val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/csr_trap_fsm.sv
// RUN/TRAP sequencer: latches a pending interrupt, decides when the trap is
// taken and when an mret is honoured, and supplies the cause to record.
module csr_trap_fsm
  import csr_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       stall_i,
  input  logic       int_i,
  input  logic [4:0] cause_i,
  input  logic       mret_i,
  output logic       take_o,
  output logic       int_rst_o,
  output logic [4:0] cause_o
);

  trap_state_e state_q, state_d;
  logic        pend_q,  pend_d;
  logic [4:0]  cause_q, cause_d;
  logic        in_run;

  assign in_run = (state_q == ST_RUN);

  // Trap fires with zero latency from an unstalled interrupt; interrupts are
  // ignored entirely while a trap is being serviced.
  assign take_o    = in_run & (pend_q | int_i) & ~stall_i;
  assign int_rst_o = mret_i & ~stall_i & ~take_o;
  // A live interrupt wins over the latched one when both are present.
  assign cause_o   = int_i ? cause_i : cause_q;

  // Next-state logic for the state, pending flag and captured cause
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pend_d  = pend_q;
    cause_d = cause_q;
    if (take_o) begin
      state_d = ST_TRAP;
      pend_d  = 1'b0;
    end else if (in_run && int_i) begin
      // Only reachable under stall: hold the request until it can be taken.
      pend_d  = 1'b1;
      cause_d = cause_i;
    end else if (!in_run && mret_i && !stall_i) begin
      state_d = ST_RUN;
    end
  end

  // State registers; reset drops any pending interrupt and returns to RUN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
      pend_q  <= 1'b0;
      cause_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q <= state_d;
      pend_q  <= pend_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: rtl/csr_controller.sv
// Machine-mode CSR block: mie/mtvec/mscratch/mepc/mcause register file,
// CSRRW/CSRRS/CSRRC execution and trap entry / mret redirect.
module csr_controller
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wd_i,
  input  logic [31:0] csr_pc_i,
  input  logic        csr_stall_i,
  input  logic        csr_mret_i,
  input  logic        csr_int_i,
  input  logic [31:0] csr_mcause_i,
  output logic [31:0] csr_rd_o,
  output logic        csr_illegal_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mtvec_o,
  output logic [31:0] csr_mepc_o,
  output logic        csr_trap_o,
  output logic        csr_int_rst_o
);

  localparam logic [31:0] MTVEC_RST = RESET_MTVEC & ALIGN_MASK;

  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [31:0] old_val, wr_val, trap_cause;
  logic        addr_hit, op_valid, wr_en, take;
  logic [4:0]  cause5;

  // Only the interrupt id bits of the cause input carry information.
  logic unused_mcause;
  assign unused_mcause = ^csr_mcause_i[31:5];

  csr_trap_fsm u_trap_fsm (
    .clk       (clk),
    .reset     (reset),
    .stall_i   (csr_stall_i),
    .int_i     (csr_int_i),
    .cause_i   (csr_mcause_i[4:0]),
    .mret_i    (csr_mret_i),
    .take_o    (take),
    .int_rst_o (csr_int_rst_o),
    .cause_o   (cause5)
  );

  // Address decode and old-value read mux
  always_comb begin
    addr_hit = 1'b1;
    old_val  = '0;
    case (csr_addr_i)
      CSR_MIE:      old_val = mie_q;
      CSR_MTVEC:    old_val = mtvec_q;
      CSR_MSCRATCH: old_val = mscratch_q;
      CSR_MEPC:     old_val = mepc_q;
      CSR_MCAUSE:   old_val = mcause_q;
      default:      addr_hit = 1'b0;
    endcase
  end

  // mcause value recorded on trap entry: interrupt flag plus 5-bit id
  always_comb begin
    trap_cause             = '0;
    trap_cause[MCAUSE_INT] = 1'b1;
    trap_cause[4:0]        = cause5;
  end

  assign op_valid = csr_op_valid(csr_op_i);
  // A trap in the same cycle squashes the instruction so it re-executes.
  assign wr_en    = op_valid & addr_hit & ~csr_stall_i & ~take;
  assign wr_val   = csr_apply(csr_op_i, old_val, csr_wd_i);

  assign csr_rd_o      = (op_valid && addr_hit) ? old_val : 32'h0;
  assign csr_illegal_o = op_valid & ~addr_hit;
  assign csr_trap_o    = take;
  assign csr_mie_o     = mie_q;
  assign csr_mtvec_o   = mtvec_q;
  assign csr_mepc_o    = mepc_q;

  // CSR register file: trap entry has priority over software writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (take) begin
      mepc_q   <= csr_pc_i & ALIGN_MASK;
      mcause_q <= trap_cause;
    end else if (wr_en) begin
      case (csr_addr_i)
        CSR_MIE:      mie_q      <= wr_val;
        CSR_MTVEC:    mtvec_q    <= wr_val & ALIGN_MASK;
        CSR_MSCRATCH: mscratch_q <= wr_val;
        CSR_MEPC:     mepc_q     <= wr_val & ALIGN_MASK;
        CSR_MCAUSE:   mcause_q   <= wr_val;
        default:      ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_controller.sv
// Self-checking bench for csr_controller: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the CSR file and trap sequencing.
module tb_csr_controller;

  localparam logic [31:0] RST_MTVEC = 32'h0000_1007;
  localparam logic [31:0] RST_MTVEC_EXP = 32'h0000_1004;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  csr_op_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wd_i, csr_pc_i, csr_mcause_i;
  logic        csr_stall_i, csr_mret_i, csr_int_i;
  logic [31:0] csr_rd_o, csr_mie_o, csr_mtvec_o, csr_mepc_o;
  logic        csr_illegal_o, csr_trap_o, csr_int_rst_o;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  csr_controller #(.RESET_MTVEC(RST_MTVEC)) dut (
    .clk           (clk),
    .reset         (reset),
    .csr_op_i      (csr_op_i),
    .csr_addr_i    (csr_addr_i),
    .csr_wd_i      (csr_wd_i),
    .csr_pc_i      (csr_pc_i),
    .csr_stall_i   (csr_stall_i),
    .csr_mret_i    (csr_mret_i),
    .csr_int_i     (csr_int_i),
    .csr_mcause_i  (csr_mcause_i),
    .csr_rd_o      (csr_rd_o),
    .csr_illegal_o (csr_illegal_o),
    .csr_mie_o     (csr_mie_o),
    .csr_mtvec_o   (csr_mtvec_o),
    .csr_mepc_o    (csr_mepc_o),
    .csr_trap_o    (csr_trap_o),
    .csr_int_rst_o (csr_int_rst_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_csr [int];   // implemented CSRs keyed by address
  bit          m_trap;        // a trap is being serviced
  bit          m_pend;        // interrupt waiting to be taken
  logic [4:0]  m_cause;

  function automatic void model_reset();
    m_csr.delete();
    m_csr['h304] = 32'h0;
    m_csr['h305] = RST_MTVEC & 32'hFFFF_FFFC;
    m_csr['h340] = 32'h0;
    m_csr['h341] = 32'h0;
    m_csr['h342] = 32'h0;
    m_trap  = 1'b0;
    m_pend  = 1'b0;
    m_cause = '0;
  endfunction

  function automatic bit m_is_access();
    return csr_op_i == 3'd1 || csr_op_i == 3'd2 || csr_op_i == 3'd3;
  endfunction

  function automatic bit m_take();
    return !m_trap && (m_pend || csr_int_i) && !csr_stall_i;
  endfunction

  function automatic void model_step();
    int          a;
    logic [31:0] old_v, new_v;
    a = int'(csr_addr_i);
    if (csr_stall_i) begin
      if (!m_trap && csr_int_i) begin
        m_pend  = 1'b1;
        m_cause = csr_mcause_i[4:0];
      end
      return;
    end
    if (m_take()) begin
      m_csr['h341] = csr_pc_i & 32'hFFFF_FFFC;
      m_csr['h342] = 32'h8000_0000 + 32'(csr_int_i ? csr_mcause_i[4:0] : m_cause);
      m_pend = 1'b0;
      m_trap = 1'b1;
      return;
    end
    if (m_is_access() && m_csr.exists(a)) begin
      old_v = m_csr[a];
      if (csr_op_i == 3'd1)      new_v = csr_wd_i;
      else if (csr_op_i == 3'd2) new_v = old_v | csr_wd_i;
      else                       new_v = old_v & ~csr_wd_i;
      if (a == 'h305 || a == 'h341) new_v = new_v & 32'hFFFF_FFFC;
      m_csr[a] = new_v;
    end
    if (m_trap && csr_mret_i) m_trap = 1'b0;
  endfunction

  always @(posedge clk) if (reset) model_step();

  // Compare every cycle, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      int          a;
      bit          known, take;
      logic [31:0] exp_rd;
      a      = int'(csr_addr_i);
      known  = m_csr.exists(a);
      take   = m_take();
      exp_rd = (m_is_access() && known) ? m_csr[a] : 32'h0;
      check("rd",      csr_rd_o, exp_rd);
      check("illegal", 32'(csr_illegal_o), 32'(m_is_access() && !known));
      check("trap",    32'(csr_trap_o), 32'(take));
      check("int_rst", 32'(csr_int_rst_o), 32'(csr_mret_i && !csr_stall_i && !take));
      check("mie",     csr_mie_o,   m_csr['h304]);
      check("mtvec",   csr_mtvec_o, m_csr['h305]);
      check("mepc",    csr_mepc_o,  m_csr['h341]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    csr_op_i     = 3'b000;
    csr_addr_i   = 12'h000;
    csr_wd_i     = 32'h0;
    csr_stall_i  = 1'b0;
    csr_mret_i   = 1'b0;
    csr_int_i    = 1'b0;
    csr_mcause_i = 32'h0;
  endtask

  task automatic access(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd);
    csr_op_i   = op;
    csr_addr_i = addr;
    csr_wd_i   = wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [11:0] addrs [6];
    addrs = '{12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h7C0};
    reset    = 1'b0;
    csr_pc_i = 32'h0;
    idle();
    model_reset();
    cmp_en = 1'b1;

    // Reset values
    #12;
    check("rst_mtvec", csr_mtvec_o, RST_MTVEC_EXP);
    check("rst_mie",   csr_mie_o,   32'h0);
    check("rst_mepc",  csr_mepc_o,  32'h0);
    check("rst_rd",    csr_rd_o,    32'h0);
    check("rst_flags", {29'h0, csr_illegal_o, csr_trap_o, csr_int_rst_o}, 32'h0);
    reset = 1'b1;
    tick();

    // Read-back: forced mtvec bits and RS/RC on mie
    access(3'b001, 12'h305, 32'h0000_0103); tick();
    check("mtvec_rw", csr_mtvec_o, 32'h0000_0100);
    access(3'b010, 12'h304, 32'h0000_0030); tick();
    access(3'b011, 12'h304, 32'h0000_0010); tick();
    check("mie_rs_rc", csr_mie_o, 32'h0000_0020);
    idle();

    // Trap entry, zero latency
    csr_pc_i = 32'h0000_0040; csr_int_i = 1'b1; csr_mcause_i = 32'd5;
    #1 check("trap_now", 32'(csr_trap_o), 32'd1);
    tick(); idle();
    check("trap_mepc", csr_mepc_o, 32'h0000_0040);
    access(3'b010, 12'h342, 32'h0);
    #1 check("trap_mcause", csr_rd_o, 32'h8000_0005);
    // Interrupt in TRAP is ignored
    idle(); csr_int_i = 1'b1; csr_mcause_i = 32'd9;
    #1 check("trap_ign_int", 32'(csr_trap_o), 32'd0);
    tick(); idle();

    // Return
    csr_mret_i = 1'b1;
    #1 check("mret_rst", 32'(csr_int_rst_o), 32'd1);
    check("mret_mepc", csr_mepc_o, 32'h0000_0040);
    tick(); idle();
    #1 check("mret_once", 32'(csr_int_rst_o), 32'd0);
    check("no_late_trap", 32'(csr_trap_o), 32'd0);

    // Stalled interrupt: pulse under stall, taken in first free cycle
    csr_stall_i = 1'b1; csr_int_i = 1'b1; csr_mcause_i = 32'd3;
    #1 check("stall_notrap0", 32'(csr_trap_o), 32'd0);
    tick(); csr_int_i = 1'b0; csr_mcause_i = 32'd0;
    #1 check("stall_notrap1", 32'(csr_trap_o), 32'd0);
    tick();
    #1 check("stall_notrap2", 32'(csr_trap_o), 32'd0);
    tick(); csr_stall_i = 1'b0; csr_pc_i = 32'h0000_0080;
    #1 check("stall_trap", 32'(csr_trap_o), 32'd1);
    tick(); idle();
    access(3'b010, 12'h342, 32'h0);
    #1 check("stall_cause", csr_rd_o, 32'h8000_0003);
    idle(); csr_mret_i = 1'b1; tick(); idle();

    // Collision: trap squashes the CSR write
    access(3'b001, 12'h340, 32'hDEAD_BEEF); csr_int_i = 1'b1; csr_mcause_i = 32'd1;
    #1 check("coll_trap", 32'(csr_trap_o), 32'd1);
    tick(); idle();
    access(3'b010, 12'h340, 32'h0);
    #1 check("coll_mscratch", csr_rd_o, 32'h0);
    idle(); csr_mret_i = 1'b1; tick(); idle();

    // Illegal address
    access(3'b001, 12'h7C0, 32'h0000_00FF);
    #1 check("illegal", 32'(csr_illegal_o), 32'd1);
    check("illegal_rd", csr_rd_o, 32'h0);
    tick(); idle();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      csr_op_i     = 3'($urandom_range(0, 7));
      csr_addr_i   = addrs[$urandom_range(0, 5)];
      csr_wd_i     = $urandom();
      csr_pc_i     = $urandom();
      csr_stall_i  = ($urandom_range(0, 4) == 0);
      csr_mret_i   = ($urandom_range(0, 5) == 0);
      csr_int_i    = ($urandom_range(0, 7) == 0);
      csr_mcause_i = $urandom();
      tick();
    end
    idle();
    tick();

    // Asynchronous reset while in TRAP
    csr_pc_i = 32'h0000_0100; csr_int_i = 1'b1; csr_mcause_i = 32'd7;
    tick(); idle();
    access(3'b001, 12'h304, 32'h0000_0888); tick(); idle();
    check("pre_rst_mie", csr_mie_o, 32'h0000_0888);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    check("arst_mie",   csr_mie_o,   32'h0);
    check("arst_mepc",  csr_mepc_o,  32'h0);
    check("arst_mtvec", csr_mtvec_o, RST_MTVEC_EXP);
    tick();
    reset = 1'b1;
    tick();
    csr_mret_i = 1'b1;
    #1 check("arst_run_mret", 32'(csr_int_rst_o), 32'd1);
    check("arst_no_pend", 32'(csr_trap_o), 32'd0);
    tick(); idle();
    tick();

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
